// File: rtl/sccpu_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sccpu_run_ctrl_pkg
//   Shared definitions for the single-cycle CPU run/step/halt sequencer.
//   The state encoding is also consumed by the board display mux, so the
//   numeric values of run_state_t must stay fixed.
//
//   Contents:
//     DEF_SYNC_STAGES / DEF_CNT_W / DEF_BURST_W : default widths and depths
//     run_state_t                               : FSM state encoding (3 bits)
//     btn_pulse_t                               : one-cycle button pulses
// -----------------------------------------------------------------------------
package sccpu_run_ctrl_pkg;

    localparam int DEF_SYNC_STAGES = 2;   // flops per button synchronizer
    localparam int DEF_CNT_W       = 32;  // retired-instruction counter width
    localparam int DEF_BURST_W     = 16;  // burst length width

    // Encodings are visible on the display; do not renumber.
    typedef enum logic [2:0] {
        ST_HALT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_BURST = 3'd3,
        ST_BRK   = 3'd4
    } run_state_t;

    // One-cycle pulses from the four button front ends.
    typedef struct packed {
        logic halt;
        logic step;
        logic burst;
        logic run;
    } btn_pulse_t;

endpackage : sccpu_run_ctrl_pkg

// File: rtl/sccpu_run_ctrl_btn_sync_edge.sv
// -----------------------------------------------------------------------------
// sccpu_run_ctrl_btn_sync_edge
//   Brings one asynchronous push-button level into the clk domain and turns
//   its rising edge into a single-cycle pulse.
//
//   A button that rises before clock edge 1 is captured at edge 1, reaches
//   the last synchronizer flop at edge SYNC_STAGES and shows up as a pulse
//   during the following cycle, so the consumer acts on it at edge
//   SYNC_STAGES+1. Holding the button produces no further pulses.
//
//   Ports:
//     clk    in  1  system clock
//     rstn   in  1  asynchronous active-low reset (clears all flops)
//     btn    in  1  raw asynchronous button level
//     pulse  out 1  one-cycle pulse on a synchronized rising edge
// -----------------------------------------------------------------------------
module sccpu_run_ctrl_btn_sync_edge
    import sccpu_run_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES  // must be >= 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbour; blocking here
    // would collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detector: high only in the first cycle the synchronized level is 1.
    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : sccpu_run_ctrl_btn_sync_edge

// File: rtl/sccpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// sccpu_run_ctrl
//   Run/step/halt sequencer for the single-cycle CPU. Generates cpu_en, the
//   enable that gates PC advance and register-file/memory writes in the core.
//   Supports free run, single step, N-instruction burst and a PC breakpoint,
//   and counts retired instructions for the display.
//
//   Ports:
//     clk        in   1        system clock, all state on rising edge
//     rstn       in   1        asynchronous active-low reset
//     run_btn    in   1        async level; rising edge starts free run
//     step_btn   in   1        async level; rising edge executes one instruction
//     burst_btn  in   1        async level; rising edge executes burst_len instr
//     halt_btn   in   1        async level; rising edge stops
//     burst_len  in   BURST_W  burst length, sampled when a burst is accepted
//     bp_en      in   1        breakpoint enable (static switch)
//     bp_addr    in   32       breakpoint PC
//     pc         in   32       current PC from the core
//     cpu_en     out  1        core advance/write enable for this cycle
//     state      out  3        encoded FSM state (run_state_t) for display
//     bp_hit     out  1        high while stopped at the breakpoint
//     instr_cnt  out  CNT_W    instructions retired since reset (wraps)
// -----------------------------------------------------------------------------
module sccpu_run_ctrl
    import sccpu_run_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int BURST_W     = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run_btn,
    input  logic               step_btn,
    input  logic               burst_btn,
    input  logic               halt_btn,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               bp_en,
    input  logic [31:0]        bp_addr,
    input  logic [31:0]        pc,
    output logic               cpu_en,
    output logic [2:0]         state,
    output logic               bp_hit,
    output logic [CNT_W-1:0]   instr_cnt
);

    // -------------------------------------------------------------------------
    // Button front ends
    // -------------------------------------------------------------------------
    btn_pulse_t pls;

    sccpu_run_ctrl_btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_halt (
        .clk   (clk),
        .rstn  (rstn),
        .btn   (halt_btn),
        .pulse (pls.halt)
    );

    sccpu_run_ctrl_btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
        .clk   (clk),
        .rstn  (rstn),
        .btn   (step_btn),
        .pulse (pls.step)
    );

    sccpu_run_ctrl_btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_burst (
        .clk   (clk),
        .rstn  (rstn),
        .btn   (burst_btn),
        .pulse (pls.burst)
    );

    sccpu_run_ctrl_btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
        .clk   (clk),
        .rstn  (rstn),
        .btn   (run_btn),
        .pulse (pls.run)
    );

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    run_state_t         state_q;
    logic [BURST_W-1:0] cnt_q;     // instructions left in the current burst
    logic               skip_q;    // suppress the breakpoint for one retire

    // skip_q lets a resume from BRK execute the instruction at bp_addr once
    // instead of re-trapping on it immediately.
    logic bp_match;
    assign bp_match = bp_en && (pc == bp_addr) && !skip_q;

    // A zero-length burst request is dropped entirely.
    logic burst_ok;
    assign burst_ok = pls.burst && (burst_len != '0);

    // Any request that moves the FSM out of HALT/BRK (halt handled first).
    logic start_req;
    assign start_req = pls.step || burst_ok || pls.run;

    // cpu_en is combinational so the core advances in the very cycle the
    // sequencer decides to execute; a breakpoint match blocks the instruction
    // at bp_addr from retiring.
    // NOTE: every signal driven in always_comb gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        cpu_en = 1'b0;
        unique case (state_q)
            ST_STEP:         cpu_en = 1'b1;
            ST_RUN,
            ST_BURST:        cpu_en = !bp_match;
            ST_HALT, ST_BRK: cpu_en = 1'b0;
            default:         cpu_en = 1'b0;
        endcase
    end

    // Single FSM block: state, burst counter, skip flag, registered bp_hit
    // and the retired-instruction counter all update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_HALT;
            cnt_q     <= '0;
            skip_q    <= 1'b0;
            bp_hit    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            if (cpu_en) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
                skip_q    <= 1'b0;
            end

            if (pls.halt) begin
                // Halt wins over every other pulse from any state.
                state_q <= ST_HALT;
                cnt_q   <= '0;
                bp_hit  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_HALT, ST_BRK: begin
                        if (start_req) begin
                            bp_hit <= 1'b0;
                            if (state_q == ST_BRK) begin
                                skip_q <= 1'b1;
                            end
                        end
                        if (pls.step) begin
                            state_q <= ST_STEP;
                        end else if (burst_ok) begin
                            state_q <= ST_BURST;
                            cnt_q   <= burst_len;
                        end else if (pls.run) begin
                            state_q <= ST_RUN;
                        end
                    end

                    ST_STEP: begin
                        // Exactly one enabled cycle, breakpoints ignored.
                        state_q <= ST_HALT;
                    end

                    ST_RUN: begin
                        if (bp_match) begin
                            state_q <= ST_BRK;
                            bp_hit  <= 1'b1;
                        end
                    end

                    ST_BURST: begin
                        if (bp_match) begin
                            state_q <= ST_BRK;
                            bp_hit  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - BURST_W'(1);
                            if (cnt_q == BURST_W'(1)) begin
                                state_q <= ST_HALT;
                            end
                        end
                    end

                    default: begin
                        state_q <= ST_HALT;
                        bp_hit  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = state_q;

endmodule : sccpu_run_ctrl
